// File: rtl/polibot_pkg.sv
// Shared definitions for the Rubik's solver blocks: reply bytes, end-of-sequence
// default and the reply-FSM state encoding.
package polibot_pkg;

    localparam logic [7:0] ACK_BYTE_DEF  = 8'hFF;
    localparam logic [7:0] NACK_BYTE_DEF = 8'hEE;
    localparam logic [7:0] END_CODE_DEF  = 8'h00;

    typedef enum logic {
        OCIOSO  = 1'b0,
        AGUARDA = 1'b1
    } estado_t;

endpackage

// File: rtl/fila_sincrona.sv
// Synchronous first-word fall-through FIFO. Pop is ignored while empty. Push while
// full is accepted only if a pop happens in the same cycle.
module fila_sincrona #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           dado_in,
    output logic [WIDTH-1:0]           dado_out,
    output logic                       vazia,
    output logic                       cheia,
    output logic [$clog2(DEPTH):0]     ocupacao
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cont;
    logic             do_push;
    logic             do_pop;

    assign vazia    = (cont == '0);
    assign cheia    = (cont == DEPTH[PW:0]);
    assign ocupacao = cont;
    assign do_pop   = pop & ~vazia;
    assign do_push  = push & (~cheia | do_pop);
    // Head reads as zero while empty so the output is clean straight after reset.
    assign dado_out = vazia ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cont   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                cont <= cont + 1'b1;
            else if (do_pop && !do_push)
                cont <= cont - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= dado_in;
    end

endmodule

// File: rtl/recebe_movimentos_fila.sv
// Move-reception front end. It classifies each received byte, buffers move codes for
// the motor sequencer, and answers every byte with ACK/NACK through the UART.
module recebe_movimentos_fila
    import polibot_pkg::*;
#(
    parameter int         MOVE_WIDTH = 3,
    parameter int         DEPTH      = 16,
    parameter logic [7:0] END_CODE   = END_CODE_DEF,
    parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEF,
    parameter logic [7:0] NACK_BYTE  = NACK_BYTE_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rx_pronto,
    input  logic [7:0]                 rx_dados,
    input  logic                       tx_pronto,
    output logic                       tx_partida,
    output logic [7:0]                 tx_dados,
    output logic                       mov_valido,
    input  logic                       mov_pronto,
    output logic [MOVE_WIDTH-1:0]      movimento,
    output logic                       fim_movimentos,
    output logic [$clog2(DEPTH):0]     ocupacao,
    output logic                       erro_overflow,
    output logic                       erro_ack
);
    localparam logic [MOVE_WIDTH-1:0] END_MOV = END_CODE[MOVE_WIDTH-1:0];

    estado_t               estado;
    logic [MOVE_WIDTH-1:0] codigo;
    logic                  vazia;
    logic                  cheia;
    logic                  pop;
    logic                  eh_fim;
    logic                  aceita;
    logic                  push;
    logic [7:0]            resposta;
    logic                  pend_valido;
    logic [7:0]            pend_byte;
    logic                  seq_fim;

    // Consumer handshake: a move transfers on every cycle where mov_valido and
    // mov_pronto are both high; movimento is stable while mov_valido waits for ready.
    assign mov_valido     = ~vazia;
    assign pop            = mov_valido & mov_pronto;
    assign codigo         = rx_dados[MOVE_WIDTH-1:0];
    assign eh_fim         = (codigo == END_MOV);
    assign aceita         = ~cheia | pop;
    assign push           = rx_pronto & ~eh_fim & aceita;
    assign resposta       = (eh_fim || aceita) ? ACK_BYTE : NACK_BYTE;
    assign fim_movimentos = seq_fim & vazia;

    generate
        if (MOVE_WIDTH < 8) begin : g_sobra
            logic sobra_unused;
            assign sobra_unused = ^rx_dados[7:MOVE_WIDTH];
        end
    endgenerate

    fila_sincrona #(
        .WIDTH (MOVE_WIDTH),
        .DEPTH (DEPTH)
    ) u_fila (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .dado_in  (codigo),
        .dado_out (movimento),
        .vazia    (vazia),
        .cheia    (cheia),
        .ocupacao (ocupacao)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado        <= OCIOSO;
            tx_partida    <= 1'b0;
            tx_dados      <= 8'h00;
            pend_valido   <= 1'b0;
            pend_byte     <= 8'h00;
            seq_fim       <= 1'b0;
            erro_overflow <= 1'b0;
            erro_ack      <= 1'b0;
        end else begin
            tx_partida <= 1'b0;

            if (rx_pronto) begin
                if (eh_fim)
                    seq_fim <= 1'b1;
                else if (aceita)
                    seq_fim <= 1'b0;
                else
                    erro_overflow <= 1'b1;
            end

            case (estado)
                OCIOSO: begin
                    // A waiting reply goes first; a new one takes its place in the slot.
                    if (pend_valido) begin
                        tx_dados    <= pend_byte;
                        tx_partida  <= 1'b1;
                        estado      <= AGUARDA;
                        pend_valido <= rx_pronto;
                        pend_byte   <= resposta;
                    end else if (rx_pronto) begin
                        tx_dados   <= resposta;
                        tx_partida <= 1'b1;
                        estado     <= AGUARDA;
                    end
                end
                AGUARDA: begin
                    if (tx_pronto) estado <= OCIOSO;
                    if (rx_pronto) begin
                        if (pend_valido) begin
                            erro_ack <= 1'b1;
                        end else begin
                            pend_valido <= 1'b1;
                            pend_byte   <= resposta;
                        end
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_recebe_movimentos_fila.sv
// Bench for recebe_movimentos_fila: directed scenarios plus random traffic, every
// cycle compared against a queue-based reference model.
module tb_recebe_movimentos_fila;
    localparam int         MW   = 3;
    localparam int         D    = 4;
    localparam logic [7:0] ACK  = 8'hFF;
    localparam logic [7:0] NACK = 8'hEE;

    logic            clock = 1'b0;
    logic            reset;
    logic            rx_pronto;
    logic [7:0]      rx_dados;
    logic            tx_pronto;
    logic            tx_partida;
    logic [7:0]      tx_dados;
    logic            mov_valido;
    logic            mov_pronto;
    logic [MW-1:0]   movimento;
    logic            fim_movimentos;
    logic [2:0]      ocupacao;
    logic            erro_overflow;
    logic            erro_ack;

    always #5 clock = ~clock;

    recebe_movimentos_fila #(
        .MOVE_WIDTH (MW),
        .DEPTH      (D),
        .END_CODE   (8'h00),
        .ACK_BYTE   (ACK),
        .NACK_BYTE  (NACK)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_pronto      (rx_pronto),
        .rx_dados       (rx_dados),
        .tx_pronto      (tx_pronto),
        .tx_partida     (tx_partida),
        .tx_dados       (tx_dados),
        .mov_valido     (mov_valido),
        .mov_pronto     (mov_pronto),
        .movimento      (movimento),
        .fim_movimentos (fim_movimentos),
        .ocupacao       (ocupacao),
        .erro_overflow  (erro_overflow),
        .erro_ack       (erro_ack)
    );

    int checks   = 0;
    int failures = 0;
    int obs_pulses = 0;
    logic prev_partida = 1'b0;

    // Reference model: moves as a queue, transmitter as "busy" plus one waiting reply.
    logic [MW-1:0] m_q[$];
    bit            m_fim, m_ovf, m_ack_err, m_busy, m_slot_v, m_pulse;
    logic [7:0]    m_slot, m_tx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fim = 0; m_ovf = 0; m_ack_err = 0; m_busy = 0; m_slot_v = 0; m_pulse = 0;
        m_slot = 8'h00; m_tx = 8'h00;
    endtask

    task automatic model_step(input bit rx, input logic [7:0] d, input bit txp, input bit movp);
        logic [MW-1:0] code;
        logic [7:0]    r;
        bit            nb;
        code = d[MW-1:0];
        r    = ACK;
        nb   = m_busy;
        if (movp && m_q.size() > 0) void'(m_q.pop_front());
        if (rx) begin
            if (code == 0) m_fim = 1;
            else if (m_q.size() < D) begin m_q.push_back(code); m_fim = 0; end
            else begin m_ovf = 1; r = NACK; end
        end
        m_pulse = 0;
        if (m_busy && txp) nb = 0;
        if (!m_busy) begin
            if (m_slot_v) begin
                m_tx = m_slot; m_pulse = 1; nb = 1;
                m_slot_v = rx; m_slot = r;
            end else if (rx) begin
                m_tx = r; m_pulse = 1; nb = 1;
            end
        end else if (rx) begin
            if (m_slot_v) m_ack_err = 1;
            else begin m_slot_v = 1; m_slot = r; end
        end
        m_busy = nb;
    endtask

    task automatic check_all();
        chk("mov_valido", mov_valido, m_q.size() > 0);
        chk("movimento", movimento, (m_q.size() > 0) ? m_q[0] : '0);
        chk("ocupacao", ocupacao, m_q.size());
        chk("fim_movimentos", fim_movimentos, m_fim && m_q.size() == 0);
        chk("erro_overflow", erro_overflow, m_ovf);
        chk("erro_ack", erro_ack, m_ack_err);
        chk("tx_partida", tx_partida, m_pulse);
        chk("tx_dados", tx_dados, m_tx);
        chk("partida_consecutive", prev_partida & tx_partida, 0);
        if (tx_partida) obs_pulses++;
        prev_partida = tx_partida;
    endtask

    task automatic cycle(input bit rx, input logic [7:0] d, input bit txp, input bit movp);
        rx_pronto = rx; rx_dados = d; tx_pronto = txp; mov_pronto = movp;
        model_step(rx, d, txp, movp);
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0; rx_pronto = 0; rx_dados = 8'h00; tx_pronto = 0; mov_pronto = 0;
        model_reset();
        @(posedge clock);
        #1;
        obs_pulses = 0;
        prev_partida = 1'b0;
        check_all();
        reset = 1'b1;
    endtask

    // Send a byte, wait a cycle, then complete its transmission.
    task automatic send_acked(input logic [7:0] d);
        cycle(1, d, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 0);
    endtask

    initial begin
        reset = 1'b0; rx_pronto = 0; rx_dados = 8'h00; tx_pronto = 0; mov_pronto = 0;
        model_reset();

        // 1: two moves and an end code
        do_reset();
        send_acked(8'h03);
        send_acked(8'h05);
        send_acked(8'h00);
        chk("t1_pulses", obs_pulses, 3);
        chk("t1_tx_dados", tx_dados, 8'hFF);
        chk("t1_ocupacao", ocupacao, 2);
        chk("t1_head0", movimento, 3);
        cycle(0, 8'h00, 0, 1);
        chk("t1_head1", movimento, 5);
        cycle(0, 8'h00, 0, 1);
        chk("t1_fim", fim_movimentos, 1);

        // 2: overflow with DEPTH=4
        do_reset();
        for (int i = 1; i <= 5; i++) send_acked(8'(i));
        chk("t2_ocupacao", ocupacao, 4);
        chk("t2_nack", tx_dados, 8'hEE);
        chk("t2_ovf", erro_overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_drain", movimento, i);
            cycle(0, 8'h00, 0, 1);
        end
        chk("t2_empty", mov_valido, 0);

        // 3: push and pop together while full
        do_reset();
        for (int i = 1; i <= 4; i++) send_acked(8'(i));
        cycle(1, 8'h02, 0, 1);
        chk("t3_ocupacao", ocupacao, 4);
        chk("t3_ack", tx_dados, 8'hFF);
        chk("t3_ovf", erro_overflow, 0);
        cycle(0, 8'h00, 1, 0);

        // 4: reply slot overrun
        do_reset();
        cycle(1, 8'h01, 0, 0); cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h02, 0, 0); cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h03, 0, 0); cycle(0, 8'h00, 0, 0);
        chk("t4_erro_ack", erro_ack, 1);
        chk("t4_pulses_before", obs_pulses, 1);
        cycle(0, 8'h00, 1, 0); cycle(0, 8'h00, 0, 0); cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 0);
        chk("t4_pulses_after", obs_pulses, 2);

        // 5: end code, then a new move
        do_reset();
        send_acked(8'h00);
        chk("t5_fim_set", fim_movimentos, 1);
        cycle(1, 8'h01, 0, 0);
        chk("t5_fim_clear", fim_movimentos, 0);
        chk("t5_stored", movimento, 1);
        cycle(0, 8'h00, 1, 0);

        // 6: reset mid-transmission with three stored moves
        do_reset();
        send_acked(8'h01);
        send_acked(8'h02);
        cycle(1, 8'h03, 0, 0);
        chk("t6_pre_ocupacao", ocupacao, 3);
        do_reset();
        chk("t6_ocupacao", ocupacao, 0);
        chk("t6_tx_dados", tx_dados, 0);
        for (int i = 0; i < 6; i++) cycle(0, 8'h00, i[0], 0);
        chk("t6_no_partida", obs_pulses, 0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
